// File: rtl/cricket_score_engine.sv
// Two-innings cricket scoring core: synchronises the bowl button and outcome switches,
// scores each ball and sequences INN1 -> BREAK -> INN2 -> DONE. Optional macro: BTN_DEBOUNCE_EN.
module cricket_score_engine #(
    parameter int unsigned MAX_BALLS       = 12,
    parameter int unsigned MAX_WICKETS     = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk_fpga,
    input  logic       rst_n,
    input  logic       btn_bowl,
    input  logic [2:0] sw_outcome,
    output logic [7:0] binaryRuns,
    output logic [3:0] binaryWickets,
    output logic [4:0] ballCount,
    output logic       inningOver,
    output logic       gameOver,
    output logic       winner
);

    localparam logic [1:0] StInn1  = 2'd0;
    localparam logic [1:0] StBreak = 2'd1;
    localparam logic [1:0] StInn2  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [3:0] MaxWk    = 4'(MAX_WICKETS);
    localparam logic [4:0] MaxBalls = 5'(MAX_BALLS);

    logic       btn_s1_q, btn_s2_q, btn_prev_q;
    logic [2:0] sw_s1_q, sw_s2_q;
    logic       btn_lvl;
    logic       bowl_evt;

    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            sw_s1_q    <= 3'd0;
            sw_s2_q    <= 3'd0;
            btn_prev_q <= 1'b0;
        end else begin
            btn_s1_q   <= btn_bowl;
            btn_s2_q   <= btn_s1_q;
            sw_s1_q    <= sw_outcome;
            sw_s2_q    <= sw_s1_q;
            btn_prev_q <= btn_lvl;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CntW-1:0] db_cnt_q, db_cnt_d;
    logic            btn_db_q, btn_db_d;

    // Filtered level flips only after the raw level has differed for DEBOUNCE_CYCLES cycles.
    always_comb begin
        btn_db_d = btn_db_q;
        db_cnt_d = '0;
        if (btn_s2_q != btn_db_q) begin
            if (db_cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                btn_db_d = btn_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q <= '0;
            btn_db_q <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            btn_db_q <= btn_db_d;
        end
    end

    assign btn_lvl = btn_db_q;
`else
    logic unused_debounce;
    assign unused_debounce = ^DEBOUNCE_CYCLES;
    assign btn_lvl         = btn_s2_q;
`endif

    assign bowl_evt = btn_lvl & ~btn_prev_q;

    logic [1:0] state_q, state_d;
    logic [7:0] runs_q, runs_d;
    logic [3:0] wk_q, wk_d;
    logic [4:0] balls_q, balls_d;
    logic [8:0] target_q, target_d;
    logic       winner_q, winner_d;

    logic [2:0] run_add;
    logic       is_wicket, is_wide;
    logic [8:0] run_sum;
    logic [7:0] runs_upd;
    logic [3:0] wk_upd;
    logic [4:0] balls_upd;
    logic       limit_hit, target_hit;

    always_comb begin
        run_add = 3'd0;
        case (sw_s2_q)
            3'b001:  run_add = 3'd1;
            3'b010:  run_add = 3'd2;
            3'b011:  run_add = 3'd3;
            3'b100:  run_add = 3'd4;
            3'b101:  run_add = 3'd6;
            3'b111:  run_add = 3'd1;
            default: run_add = 3'd0;
        endcase
        is_wicket  = (sw_s2_q == 3'b110);
        is_wide    = (sw_s2_q == 3'b111);
        run_sum    = {1'b0, runs_q} + {6'd0, run_add};
        runs_upd   = run_sum[8] ? 8'hFF : run_sum[7:0];
        wk_upd     = wk_q + {3'd0, is_wicket};
        balls_upd  = balls_q + {4'd0, ~is_wide};
        limit_hit  = (wk_upd >= MaxWk) || (balls_upd >= MaxBalls);
        // Saturated runs can never reach a target of 256.
        target_hit = ({1'b0, runs_upd} >= target_q);
    end

    always_comb begin
        state_d  = state_q;
        runs_d   = runs_q;
        wk_d     = wk_q;
        balls_d  = balls_q;
        target_d = target_q;
        winner_d = winner_q;
        if (bowl_evt) begin
            case (state_q)
                StInn1: begin
                    runs_d  = runs_upd;
                    wk_d    = wk_upd;
                    balls_d = balls_upd;
                    if (limit_hit) begin
                        state_d  = StBreak;
                        target_d = {1'b0, runs_upd} + 9'd1;
                    end
                end
                StBreak: begin
                    state_d = StInn2;
                    runs_d  = 8'd0;
                    wk_d    = 4'd0;
                    balls_d = 5'd0;
                end
                StInn2: begin
                    runs_d  = runs_upd;
                    wk_d    = wk_upd;
                    balls_d = balls_upd;
                    if (target_hit) begin
                        state_d  = StDone;
                        winner_d = 1'b1;
                    end else if (limit_hit) begin
                        state_d  = StDone;
                        winner_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StInn1;
            runs_q   <= 8'd0;
            wk_q     <= 4'd0;
            balls_q  <= 5'd0;
            target_q <= 9'd0;
            winner_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            runs_q   <= runs_d;
            wk_q     <= wk_d;
            balls_q  <= balls_d;
            target_q <= target_d;
            winner_q <= winner_d;
        end
    end

    assign binaryRuns    = runs_q;
    assign binaryWickets = wk_q;
    assign ballCount     = balls_q;
    assign inningOver    = (state_q == StBreak);
    assign gameOver      = (state_q == StDone);
    assign winner        = winner_q;

endmodule

// File: tb/tb_cricket_score_engine.sv
// Bench for cricket_score_engine: directed and random ball sequences checked against a
// behavioural match model. Define BTN_DEBOUNCE_EN to exercise the debounce build.
module tb_cricket_score_engine;

`ifdef BTN_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 0;
`endif
    localparam int HOLD = DB + 4;
    localparam int GAP  = DB + 4;
    localparam int MB   = 12;
    localparam int MW   = 10;

    logic       clk_fpga = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_bowl = 1'b0;
    logic [2:0] sw_outcome = 3'd0;
    logic [7:0] binaryRuns;
    logic [3:0] binaryWickets;
    logic [4:0] ballCount;
    logic       inningOver, gameOver, winner;

    cricket_score_engine #(
        .MAX_BALLS      (MB),
        .MAX_WICKETS    (MW),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk_fpga     (clk_fpga),
        .rst_n        (rst_n),
        .btn_bowl     (btn_bowl),
        .sw_outcome   (sw_outcome),
        .binaryRuns   (binaryRuns),
        .binaryWickets(binaryWickets),
        .ballCount    (ballCount),
        .inningOver   (inningOver),
        .gameOver     (gameOver),
        .winner       (winner)
    );

    always #5 clk_fpga = ~clk_fpga;

    int checks = 0;
    int failures = 0;
    int nball = 0;

    // Match model: phase 0 = first innings, 1 = break, 2 = second innings, 3 = over.
    int m_phase, m_runs, m_wk, m_balls, m_target, m_winner;
    int run_val [8] = '{0, 1, 2, 3, 4, 6, 0, 1};

    logic [2:0] seq20_inn1 [12] = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd2, 3'd2,
                                    3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    logic [2:0] seq21_inn2 [5]  = '{3'd5, 3'd5, 3'd4, 3'd4, 3'd1};

    task automatic model_reset();
        m_phase = 0; m_runs = 0; m_wk = 0; m_balls = 0; m_target = 0; m_winner = 0;
    endtask

    task automatic model_ball(input logic [2:0] code);
        int c;
        c = int'(code);
        if (m_phase == 1) begin
            m_phase = 2; m_runs = 0; m_wk = 0; m_balls = 0;
        end else if (m_phase == 0 || m_phase == 2) begin
            m_runs = m_runs + run_val[c];
            if (m_runs > 255) m_runs = 255;
            if (c == 6) m_wk++;
            if (c != 7) m_balls++;
            if (m_phase == 0) begin
                if (m_wk == MW || m_balls == MB) begin
                    m_phase = 1; m_target = m_runs + 1;
                end
            end else if (m_runs >= m_target) begin
                m_phase = 3; m_winner = 1;
            end else if (m_wk == MW || m_balls == MB) begin
                m_phase = 3; m_winner = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/runs"}, 32'(binaryRuns), m_runs);
        check({tag, "/wickets"}, 32'(binaryWickets), m_wk);
        check({tag, "/balls"}, 32'(ballCount), m_balls);
        check({tag, "/inningOver"}, 32'(inningOver), (m_phase == 1) ? 1 : 0);
        check({tag, "/gameOver"}, 32'(gameOver), (m_phase == 3) ? 1 : 0);
        check({tag, "/winner"}, 32'(winner), m_winner);
    endtask

    task automatic bowl(input logic [2:0] code);
        sw_outcome = code;
        btn_bowl = 1'b1;
        repeat (HOLD) @(posedge clk_fpga);
        #1 btn_bowl = 1'b0;
        repeat (GAP) @(posedge clk_fpga);
        #1;
        model_ball(code);
        check_all($sformatf("ball%0d", nball));
        nball++;
    endtask

    // Asserts reset between clock edges so the zeroed outputs must be asynchronous.
    task automatic do_reset(input string tag);
        btn_bowl = 1'b0;
        sw_outcome = 3'd0;
        @(posedge clk_fpga);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk_fpga);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int n;
        model_reset();
        repeat (3) @(posedge clk_fpga);
        #1;
        check_all("por");
        rst_n = 1'b1;

        // 1: basic scoring and update latency
        do_reset("rst1");
`ifndef BTN_DEBOUNCE_EN
        sw_outcome = 3'b100;
        btn_bowl = 1'b1;
        @(posedge clk_fpga);
        @(posedge clk_fpga);
        #1 check("latency_edge2", 32'(binaryRuns), 0);
        @(posedge clk_fpga);
        #1 check("latency_edge3", 32'(binaryRuns), 4);
        @(posedge clk_fpga);
        #1 btn_bowl = 1'b0;
        repeat (GAP) @(posedge clk_fpga);
        #1 model_ball(3'b100);
        check_all("latency_ball");
`else
        bowl(3'b100);
`endif
        bowl(3'b101);
        bowl(3'b001);
        check("s1_runs", 32'(binaryRuns), 11);
        check("s1_balls", 32'(ballCount), 3);
        check("s1_wickets", 32'(binaryWickets), 0);

        // 2: ten wickets end innings 1, next event opens innings 2
        do_reset("rst2");
        for (int i = 0; i < 10; i++) bowl(3'b110);
        check("s2_wickets", 32'(binaryWickets), 10);
        check("s2_break", 32'(inningOver), 1);
        bowl(3'b011);
        check("s2_inn2_runs", 32'(binaryRuns), 0);
        check("s2_inn2_break", 32'(inningOver), 0);

        // 3: chase reaches 21 on ball 5
        do_reset("rst3");
        for (int i = 0; i < 12; i++) bowl(seq20_inn1[i]);
        check("s3_inn1_runs", 32'(binaryRuns), 20);
        check("s3_inn1_break", 32'(inningOver), 1);
        bowl(3'b000);
        for (int i = 0; i < 5; i++) bowl(seq21_inn2[i]);
        check("s3_done", 32'(gameOver), 1);
        check("s3_winner", 32'(winner), 1);
        bowl(3'b101);
        bowl(3'b110);
        check("s3_frozen_runs", 32'(binaryRuns), 21);
        check("s3_frozen_balls", 32'(ballCount), 5);

        // 4: tie on 20 goes to team A
        do_reset("rst4");
        for (int i = 0; i < 12; i++) bowl(seq20_inn1[i]);
        bowl(3'b000);
        for (int i = 0; i < 12; i++) bowl(seq20_inn1[i]);
        check("s4_done", 32'(gameOver), 1);
        check("s4_winner", 32'(winner), 0);
        check("s4_runs", 32'(binaryRuns), 20);

        // 5: wides are free balls, runs saturate, target 256 is unreachable
        do_reset("rst5");
        for (int i = 0; i < 11; i++) bowl(3'b111);
        for (int i = 0; i < 10; i++) bowl(3'b101);
        check("s5_runs", 32'(binaryRuns), 71);
        check("s5_balls", 32'(ballCount), 10);
        check("s5_no_break", 32'(inningOver), 0);
        for (int i = 0; i < 200; i++) bowl(3'b111);
        check("s5_saturate", 32'(binaryRuns), 255);
        bowl(3'b101);
        bowl(3'b111);
        check("s5_last_wide_balls", 32'(ballCount), 11);
        check("s5_last_wide_open", 32'(inningOver), 0);
        bowl(3'b110);
        check("s5_break", 32'(inningOver), 1);
        bowl(3'b000);
        for (int i = 0; i < 255; i++) bowl(3'b111);
        for (int i = 0; i < 12; i++) bowl(3'b000);
        check("s5_done", 32'(gameOver), 1);
        check("s5_winner", 32'(winner), 0);

        // Target and ball limit reached together: target wins
        do_reset("rst7");
        for (int i = 0; i < 10; i++) bowl(3'b110);
        bowl(3'b000);
        for (int i = 0; i < 11; i++) bowl(3'b000);
        bowl(3'b001);
        check("s7_winner", 32'(winner), 1);
        check("s7_balls", 32'(ballCount), 12);

        // Random games
        for (int g = 0; g < 5; g++) begin
            do_reset($sformatf("rst_rand%0d", g));
            n = 0;
            while (m_phase != 3 && n < 80) begin
                bowl(3'($urandom_range(0, 7)));
                n++;
            end
            bowl(3'($urandom_range(0, 7)));
        end

        // 6: asynchronous reset in the middle of innings 2
        do_reset("rst6");
        n = 0;
        while (!(m_phase == 2 && m_balls >= 2) && m_phase != 3 && n < 80) begin
            bowl(3'($urandom_range(0, 5)));
            n++;
        end
        do_reset("mid_inn2_reset");

`ifdef BTN_DEBOUNCE_EN
        sw_outcome = 3'b101;
        btn_bowl = 1'b1;
        repeat (3) @(posedge clk_fpga);
        #1 btn_bowl = 1'b0;
        repeat (GAP) @(posedge clk_fpga);
        #1 check_all("glitch3");
        btn_bowl = 1'b1;
        repeat (6) @(posedge clk_fpga);
        #1 btn_bowl = 1'b0;
        repeat (GAP) @(posedge clk_fpga);
        #1 model_ball(3'b101);
        check_all("pulse6");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
